// File: rtl/micro_sequencer_if.sv
// Control bus between the micro_sequencer and its surroundings (IR, memory handshake, ucode ROM).
// Optional irq signal is present when MICRO_SEQUENCER_IRQ_EN is defined.
interface micro_sequencer_if #(
  parameter int unsigned OP_W    = 8,
  parameter int unsigned STEP_W  = 4,
  parameter int unsigned STATE_W = 8
) ();
  logic                    run;
  logic [OP_W-1:0]         opcode;
  logic                    mem_ready;
  logic [OP_W+STEP_W-1:0]  ucode_addr;
  logic [STATE_W-1:0]      ucode_state;
  logic                    ucode_last;
  logic                    ucode_wait;
  logic [STATE_W-1:0]      state;
  logic                    instr_done;
  logic                    halted;
  logic                    fault;
`ifdef MICRO_SEQUENCER_IRQ_EN
  logic                    irq;
`endif

  modport master (
`ifdef MICRO_SEQUENCER_IRQ_EN
    output irq,
`endif
    output run, opcode, mem_ready, ucode_state, ucode_last, ucode_wait,
    input  ucode_addr, state, instr_done, halted, fault
  );

  modport slave (
`ifdef MICRO_SEQUENCER_IRQ_EN
    input  irq,
`endif
    input  run, opcode, mem_ready, ucode_state, ucode_last, ucode_wait,
    output ucode_addr, state, instr_done, halted, fault
  );
endinterface

// File: rtl/micro_sequencer.sv
// Microcode control sequencer: fixed fetch phase, then microcode words indexed by {opcode, ustep}.
// Define MICRO_SEQUENCER_IRQ_EN to add irq entry (IRQ_OPCODE) and irq-based halt exit.
module micro_sequencer #(
  parameter int unsigned        OP_W          = 8,
  parameter int unsigned        STEP_W        = 4,
  parameter int unsigned        STATE_W       = 8,
  parameter logic [STATE_W-1:0] ST_NEXT       = STATE_W'(8'h00),
  parameter logic [STATE_W-1:0] ST_FETCH_PC   = STATE_W'(8'h01),
  parameter logic [STATE_W-1:0] ST_FETCH_INST = STATE_W'(8'h02),
  parameter logic [STATE_W-1:0] ST_DECODE     = STATE_W'(8'h03),
  parameter logic [STATE_W-1:0] ST_HALT       = STATE_W'(8'hFF)
`ifdef MICRO_SEQUENCER_IRQ_EN
  ,
  parameter logic [OP_W-1:0]    IRQ_OPCODE    = '1
`endif
) (
  input  logic              clk,
  input  logic              reset,
  micro_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    PhNext, PhFetchPc, PhFetchInst, PhDecode, PhExec, PhHalt
  } phase_e;

  phase_e             phase;
  logic [STATE_W-1:0] state_q, state_d;
  logic [STEP_W-1:0]  ustep_q, ustep_d;
  logic               last_q, last_d;
  logic               wait_q, wait_d;
  logic               done_q, done_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;
  logic               load;
  logic [OP_W-1:0]    op_eff;

`ifdef MICRO_SEQUENCER_IRQ_EN
  logic irq_mode_q, irq_mode_d;
  assign op_eff = irq_mode_q ? IRQ_OPCODE : bus.opcode;
`else
  assign op_eff = bus.opcode;
`endif

  assign bus.ucode_addr = {op_eff, ustep_q};
  assign bus.state      = state_q;
  assign bus.instr_done = done_q & bus.run;
  assign bus.halted     = halted_q;
  assign bus.fault      = fault_q;

  // Anything that is not a fixed phase code is a microcode-supplied exec state.
  always_comb begin
    if (state_q == ST_NEXT)            phase = PhNext;
    else if (state_q == ST_FETCH_PC)   phase = PhFetchPc;
    else if (state_q == ST_FETCH_INST) phase = PhFetchInst;
    else if (state_q == ST_DECODE)     phase = PhDecode;
    else if (state_q == ST_HALT)       phase = PhHalt;
    else                               phase = PhExec;
  end

  always_comb begin
    state_d  = state_q;
    ustep_d  = ustep_q;
    last_d   = last_q;
    wait_d   = wait_q;
    done_d   = 1'b0;
    halted_d = halted_q;
    fault_d  = fault_q;
    load     = 1'b0;
`ifdef MICRO_SEQUENCER_IRQ_EN
    irq_mode_d = irq_mode_q;
`endif

    unique case (phase)
      PhNext: begin
        ustep_d = '0;
`ifdef MICRO_SEQUENCER_IRQ_EN
        irq_mode_d = bus.irq;
        state_d    = bus.irq ? ST_DECODE : ST_FETCH_PC;
`else
        state_d = ST_FETCH_PC;
`endif
      end
      PhFetchPc:   state_d = ST_FETCH_INST;
      PhFetchInst: if (bus.mem_ready) state_d = ST_DECODE;
      PhDecode:    load = 1'b1;
      PhExec: begin
        if (wait_q && !bus.mem_ready) begin
          load = 1'b0;
        end else if (last_q) begin
          state_d = ST_NEXT;
          done_d  = 1'b1;
        end else if (ustep_q == '0) begin
          // ustep only reaches 0 in exec by wrapping past the top word: overflow.
          state_d = ST_NEXT;
          fault_d = 1'b1;
        end else begin
          load = 1'b1;
        end
      end
      PhHalt: begin
`ifdef MICRO_SEQUENCER_IRQ_EN
        if (bus.irq) begin
          state_d  = ST_NEXT;
          halted_d = 1'b0;
        end
`endif
      end
      default: state_d = ST_NEXT;
    endcase

    if (load) begin
      state_d  = bus.ucode_state;
      last_d   = bus.ucode_last;
      wait_d   = bus.ucode_wait;
      ustep_d  = ustep_q + STEP_W'(1);
      halted_d = (bus.ucode_state == ST_HALT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_NEXT;
      ustep_q  <= '0;
      last_q   <= 1'b0;
      wait_q   <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
`ifdef MICRO_SEQUENCER_IRQ_EN
      irq_mode_q <= 1'b0;
`endif
    end else if (bus.run) begin
      state_q  <= state_d;
      ustep_q  <= ustep_d;
      last_q   <= last_d;
      wait_q   <= wait_d;
      done_q   <= done_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
`ifdef MICRO_SEQUENCER_IRQ_EN
      irq_mode_q <= irq_mode_d;
`endif
    end else begin
      // Frozen: the done pulse is dropped so it cannot re-fire on resume.
      done_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: main instance (STEP_W=4) plus a STEP_W=2 overflow instance.
module tb_micro_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] rom_state [4096];
  logic       rom_last  [4096];
  logic       rom_wait  [4096];

  always #5 clk = ~clk;

  micro_sequencer_if #(.OP_W(8), .STEP_W(4), .STATE_W(8)) bus ();
  micro_sequencer_if #(.OP_W(8), .STEP_W(2), .STATE_W(8)) bus2 ();

  micro_sequencer #(.OP_W(8), .STEP_W(4), .STATE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  micro_sequencer #(.OP_W(8), .STEP_W(2), .STATE_W(8)) dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  always_comb begin
    bus.ucode_state = rom_state[bus.ucode_addr];
    bus.ucode_last  = rom_last[bus.ucode_addr];
    bus.ucode_wait  = rom_wait[bus.ucode_addr];
  end

  // Second instance: state 0x20+step, last never set.
  always_comb begin
    bus2.ucode_state = {6'b001000, bus2.ucode_addr[1:0]};
    bus2.ucode_last  = 1'b0;
    bus2.ucode_wait  = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      rom_state[i] = 8'h00;
      rom_last[i]  = 1'b0;
      rom_wait[i]  = 1'b0;
    end
    rom_state[12'h120] = 8'h10; rom_last[12'h120] = 1'b1;
    rom_state[12'h340] = 8'h40;
    rom_state[12'h341] = 8'h41; rom_wait[12'h341] = 1'b1;
    rom_state[12'h342] = 8'h42; rom_last[12'h342] = 1'b1;
    rom_state[12'h560] = 8'hFF;
    rom_state[12'h780] = 8'h50;
    rom_state[12'h781] = 8'h51;
    rom_state[12'h782] = 8'h52; rom_last[12'h782] = 1'b1;

    reset = 1'b1; reset2 = 1'b1;
    bus.run = 1'b1; bus.mem_ready = 1'b1; bus.opcode = 8'h12;
    bus2.run = 1'b1; bus2.mem_ready = 1'b1; bus2.opcode = 8'h9A;
`ifdef MICRO_SEQUENCER_IRQ_EN
    bus.irq = 1'b0; bus2.irq = 1'b0;
`endif
    step(); step();
    chk("rst_state", 32'(bus.state), 32'h00);
    chk("rst_done", 32'(bus.instr_done), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);

    // 1-word instruction
    reset = 1'b0;
    step(); chk("t1_fpc", 32'(bus.state), 32'h01);
    step(); chk("t1_finst", 32'(bus.state), 32'h02);
    step(); chk("t1_dec", 32'(bus.state), 32'h03);
    chk("t1_dec_addr", 32'(bus.ucode_addr), 32'h120);
    step(); chk("t1_exec", 32'(bus.state), 32'h10);
    chk("t1_exec_done", 32'(bus.instr_done), 32'h0);
    step(); chk("t1_next", 32'(bus.state), 32'h00);
    chk("t1_done", 32'(bus.instr_done), 32'h1);
    step(); chk("t1_fpc2", 32'(bus.state), 32'h01);
    chk("t1_done_clr", 32'(bus.instr_done), 32'h0);

    // 3-word instruction with a wait-flagged word and a slow memory
    bus.opcode = 8'h34;
    step(); chk("t2_finst", 32'(bus.state), 32'h02);
    step(); chk("t2_dec", 32'(bus.state), 32'h03);
    step(); chk("t2_w0", 32'(bus.state), 32'h40);
    chk("t2_w0_addr", 32'(bus.ucode_addr), 32'h341);
    bus.mem_ready = 1'b0;
    step(); chk("t2_w1_c1", 32'(bus.state), 32'h41);
    chk("t2_w1_addr1", 32'(bus.ucode_addr), 32'h342);
    step(); chk("t2_w1_c2", 32'(bus.state), 32'h41);
    step(); chk("t2_w1_c3", 32'(bus.state), 32'h41);
    step(); chk("t2_w1_c4", 32'(bus.state), 32'h41);
    chk("t2_w1_addr4", 32'(bus.ucode_addr), 32'h342);
    bus.mem_ready = 1'b1;
    step(); chk("t2_w2", 32'(bus.state), 32'h42);
    step(); chk("t2_next", 32'(bus.state), 32'h00);
    chk("t2_done", 32'(bus.instr_done), 32'h1);

    // Halt word
    bus.opcode = 8'h56;
    step(); step(); step();
    chk("t3_dec", 32'(bus.state), 32'h03);
    step(); chk("t3_halt", 32'(bus.state), 32'hFF);
    chk("t3_halted", 32'(bus.halted), 32'h1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t3_halt_hold", 32'({bus.halted, bus.state}), 32'h1FF);
    end
`ifdef MICRO_SEQUENCER_IRQ_EN
    bus.irq = 1'b1;
    step(); chk("irq_next", 32'(bus.state), 32'h00);
    chk("irq_halted", 32'(bus.halted), 32'h0);
    step(); chk("irq_dec", 32'(bus.state), 32'h03);
    chk("irq_addr", 32'(bus.ucode_addr), 32'hFF0);
    bus.irq = 1'b0;
`endif
    reset = 1'b1;
    step(); chk("t3_rst_state", 32'(bus.state), 32'h00);
    chk("t3_rst_halted", 32'(bus.halted), 32'h0);
    reset = 1'b0;

    // Freeze with run = 0 mid-exec
    bus.opcode = 8'h78;
    step(); step(); step(); step();
    chk("t5_w0", 32'(bus.state), 32'h50);
    step(); chk("t5_w1", 32'(bus.state), 32'h51);
    bus.run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_frz_state", 32'(bus.state), 32'h51);
      chk("t5_frz_addr", 32'(bus.ucode_addr), 32'h782);
      chk("t5_frz_done", 32'(bus.instr_done), 32'h0);
    end
    bus.run = 1'b1;
    step(); chk("t5_w2", 32'(bus.state), 32'h52);
    step(); chk("t5_next", 32'(bus.state), 32'h00);
    chk("t5_done", 32'(bus.instr_done), 32'h1);
    bus.run = 1'b0;
    #1; chk("t5_done_mask", 32'(bus.instr_done), 32'h0);
    step(); chk("t5_frz_next", 32'(bus.state), 32'h00);
    chk("t5_frz_next_done", 32'(bus.instr_done), 32'h0);
    bus.run = 1'b1;
    step(); chk("t5_resume", 32'(bus.state), 32'h01);
    chk("t5_resume_done", 32'(bus.instr_done), 32'h0);
    step(); step(); step();
    chk("t5_w0b", 32'(bus.state), 32'h50);
    reset = 1'b1;
    step(); chk("t5_rst_exec", 32'(bus.state), 32'h00);
    reset = 1'b0;

    // Step overflow on the STEP_W=2 instance
    reset2 = 1'b0;
    step(); chk("t4_fpc", 32'(bus2.state), 32'h01);
    step(); step(); chk("t4_dec", 32'(bus2.state), 32'h03);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_word", 32'(bus2.state), 32'h20 + 32'(i));
      chk("t4_word_done", 32'(bus2.instr_done), 32'h0);
    end
    chk("t4_fault_pre", 32'(bus2.fault), 32'h0);
    step(); chk("t4_next", 32'(bus2.state), 32'h00);
    chk("t4_fault", 32'(bus2.fault), 32'h1);
    chk("t4_no_done", 32'(bus2.instr_done), 32'h0);
    step(); chk("t4_fpc2", 32'(bus2.state), 32'h01);
    step(); step(); step();
    chk("t4_w0b", 32'(bus2.state), 32'h20);
    chk("t4_fault_sticky", 32'(bus2.fault), 32'h1);
    chk("t4_main_fault", 32'(bus.fault), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
